// File: rtl/dpram_pkg.sv
// Shared types and lane-merge helper for the byte-enabled dual-port RAM.
package dpram_pkg;

    typedef enum logic {StClear, StRun} clr_state_e;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int unsigned MaxW = 256;

    function automatic logic [MaxW-1:0] merge(input logic [MaxW-1:0] old_w,
                                              input logic [MaxW-1:0] new_w,
                                              input logic [MaxW-1:0] be,
                                              input int unsigned     byte_w);
        logic [MaxW-1:0] res;
        res = old_w;
        for (int i = 0; i < MaxW; i++) begin
            if (be[i / byte_w]) res[i] = new_w[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sweep: walks every address once, then hands the RAM to the ports.
module dpram_clear_seq import dpram_pkg::*; #(
    parameter int unsigned widthad_a      = 10,
    parameter bit          clear_on_reset = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    output logic                 busy_o,
    output logic                 clr_we_o,
    output logic [widthad_a-1:0] clr_addr_o
);

    clr_state_e           state_q, state_d;
    logic [widthad_a-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= clear_on_reset ? StClear : StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_o   = 1'b0;
        clr_we_o = 1'b0;
        unique case (state_q)
            StClear: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = StRun;
            end
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional output
// register, same-address write collision flag and a post-reset clear sweep.
module dpram_be_clr import dpram_pkg::*; #(
    parameter int unsigned        width_a        = 8,
    parameter int unsigned        widthad_a      = 10,
    parameter int unsigned        byte_w         = 8,
    parameter bit                 rdw_new        = 1'b0,
    parameter bit                 out_reg        = 1'b0,
    parameter bit                 clear_on_reset = 1'b1,
    parameter logic [width_a-1:0] clear_value    = '0,
    parameter string              init_file      = ""
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wren_a,
    input  logic [widthad_a-1:0]        address_a,
    input  logic [width_a-1:0]          data_a,
    input  logic [width_a/byte_w-1:0]   byteena_a,
    output logic [width_a-1:0]          q_a,
    input  logic                        wren_b,
    input  logic [widthad_a-1:0]        address_b,
    input  logic [width_a-1:0]          data_b,
    input  logic [width_a/byte_w-1:0]   byteena_b,
    output logic [width_a-1:0]          q_b,
    output logic                        busy,
    output logic                        collision
);

    localparam int unsigned Depth = 2 ** widthad_a;

    if ((width_a % byte_w) != 0 || width_a > MaxW) begin : g_bad_width
        $error("dpram_be_clr: width_a must be a multiple of byte_w and at most MaxW");
    end

    logic [width_a-1:0] mem [Depth];

    logic                 busy_int;
    logic                 clr_we;
    logic [widthad_a-1:0] clr_addr;

    dpram_clear_seq #(
        .widthad_a      (widthad_a),
        .clear_on_reset (clear_on_reset)
    ) u_clear_seq (
        .clk_i      (clock),
        .reset_i    (reset),
        .busy_o     (busy_int),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign busy = busy_int;

    logic               we_a, we_b, coll;
    logic [width_a-1:0] old_a, old_b, wr_a_word, wr_b_word;
    logic [width_a-1:0] q_a_d, q_b_d, q_a_q, q_b_q, q_a_r, q_b_r;
    logic               collision_q;

    always_comb begin
        we_a  = wren_a && !busy_int && !reset;
        we_b  = wren_b && !busy_int && !reset;
        coll  = we_a && we_b && (address_a == address_b);
        old_a = mem[address_a];
        old_b = mem[address_b];
        wr_b_word = width_a'(merge(MaxW'(old_b), MaxW'(data_b), MaxW'(byteena_b), byte_w));
        // On a collision A's base already carries B's lanes, so A's later write keeps them.
        wr_a_word = width_a'(merge(MaxW'(coll ? wr_b_word : old_a), MaxW'(data_a),
                                   MaxW'(byteena_a), byte_w));
        q_a_d = (rdw_new && we_a) ? wr_a_word : old_a;
        q_b_d = (rdw_new && we_b) ? (coll ? wr_a_word : wr_b_word) : old_b;
        if (busy_int) begin
            q_a_d = '0;
            q_b_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (clr_we && !reset) begin
            mem[clr_addr] <= clear_value;
        end else begin
            if (we_b) mem[address_b] <= wr_b_word;
            if (we_a) mem[address_a] <= wr_a_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a_q       <= '0;
            q_b_q       <= '0;
            q_a_r       <= '0;
            q_b_r       <= '0;
            collision_q <= 1'b0;
        end else begin
            q_a_q       <= q_a_d;
            q_b_q       <= q_b_d;
            q_a_r       <= q_a_q;
            q_b_r       <= q_b_q;
            collision_q <= coll;
        end
    end

    assign q_a       = out_reg ? q_a_r : q_a_q;
    assign q_b       = out_reg ? q_b_r : q_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Scoreboard bench: three dpram_be_clr configurations share clock and reset.
module tb_dpram_be_clr;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: 8-bit, rdw old, clear AA
    logic       wa0 = 0, wb0 = 0;
    logic [3:0] aa0 = 0, ab0 = 0;
    logic [7:0] da0 = 0, db0 = 0, qa0, qb0;
    logic [0:0] bea0 = 0, beb0 = 0;
    logic       busy0, coll0;
    // u1: 16-bit, rdw new
    logic        wa1 = 0, wb1 = 0;
    logic [3:0]  aa1 = 0, ab1 = 0;
    logic [15:0] da1 = 0, db1 = 0, qa1, qb1;
    logic [1:0]  bea1 = 0, beb1 = 0;
    logic        busy1, coll1;
    // u2: 8-bit, rdw new, output register
    logic       wa2 = 0;
    logic [3:0] aa2 = 0;
    logic [7:0] da2 = 0, qa2, qb2;
    logic [0:0] bea2 = 0;
    logic       busy2, coll2;

    dpram_be_clr #(.width_a(8), .widthad_a(4), .byte_w(8), .rdw_new(1'b0), .out_reg(1'b0),
                   .clear_on_reset(1'b1), .clear_value(8'hAA)) u0 (
        .clock(clk), .reset(reset),
        .wren_a(wa0), .address_a(aa0), .data_a(da0), .byteena_a(bea0), .q_a(qa0),
        .wren_b(wb0), .address_b(ab0), .data_b(db0), .byteena_b(beb0), .q_b(qb0),
        .busy(busy0), .collision(coll0));

    dpram_be_clr #(.width_a(16), .widthad_a(4), .byte_w(8), .rdw_new(1'b1), .out_reg(1'b0),
                   .clear_on_reset(1'b1), .clear_value(16'h0000)) u1 (
        .clock(clk), .reset(reset),
        .wren_a(wa1), .address_a(aa1), .data_a(da1), .byteena_a(bea1), .q_a(qa1),
        .wren_b(wb1), .address_b(ab1), .data_b(db1), .byteena_b(beb1), .q_b(qb1),
        .busy(busy1), .collision(coll1));

    dpram_be_clr #(.width_a(8), .widthad_a(4), .byte_w(8), .rdw_new(1'b1), .out_reg(1'b1),
                   .clear_on_reset(1'b1), .clear_value(8'h00)) u2 (
        .clock(clk), .reset(reset),
        .wren_a(wa2), .address_a(aa2), .data_a(da2), .byteena_a(bea2), .q_a(qa2),
        .wren_b(1'b0), .address_b(4'd0), .data_b(8'h00), .byteena_b(1'b0), .q_b(qb2),
        .busy(busy2), .collision(coll2));

    typedef struct {
        int          due;
        int          src;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] obs(input int src);
        case (src)
            0:       return 16'(qa0);
            1:       return 16'(qb0);
            2:       return 16'(busy0);
            3:       return 16'(coll0);
            4:       return qa1;
            5:       return qb1;
            6:       return 16'(coll1);
            7:       return 16'(qa2);
            8:       return 16'(busy1);
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic sb_push(input int src, input int lat, input logic [15:0] v, input string tag);
        exp_t e;
        e.due = cyc + lat;
        e.src = src;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_val(sb[i].tag, obs(sb[i].src), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        tick();
        sb_push(0, 1, 16'h0, "rst_qa0");
        sb_push(2, 1, 16'h1, "rst_busy0");
        sb_push(6, 1, 16'h0, "rst_coll1");
        sb_push(7, 1, 16'h0, "rst_qa2");
        tick();

        // Start a sweep, attempt a port write, then re-reset at count 5.
        reset = 1'b0;
        wa0 = 1; aa0 = 4'd2; da0 = 8'h33; bea0 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sb_push(2, k, 16'h1, "busy_pre");
            sb_push(0, k, 16'h0, "q_zero_pre");
        end
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            sb_push(2, k, 16'h1, "busy_sweep");
            sb_push(8, k, 16'h1, "busy1_sweep");
            sb_push(0, k, 16'h0, "q_zero_sweep");
        end
        sb_push(2, 16, 16'h0, "busy_done");
        sb_push(8, 16, 16'h0, "busy1_done");
        for (int k = 0; k < 16; k++) begin
            if (k == 10) wa0 = 0;
            tick();
        end

        // Every word holds the clear value; the write during busy left no trace.
        for (int a = 0; a < 16; a++) begin
            aa0 = 4'(a);
            ab0 = 4'(15 - a);
            sb_push(0, 1, 16'h00AA, "clr_qa");
            sb_push(1, 1, 16'h00AA, "clr_qb");
            tick();
        end

        // Same-port RDW, old-data mode.
        wa0 = 1; aa0 = 4'd5; da0 = 8'h11; bea0 = 1'b1;
        sb_push(0, 1, 16'h00AA, "rdw_old_first");
        tick();
        da0 = 8'h55;
        sb_push(0, 1, 16'h0011, "rdw_old");
        tick();
        wa0 = 0;
        sb_push(0, 1, 16'h0055, "rdw_old_after");
        tick();

        // New-data mode through the output register (latency 2).
        wa2 = 1; aa2 = 4'd5; da2 = 8'h11; bea2 = 1'b1;
        sb_push(7, 2, 16'h0011, "rdw_new_11");
        tick();
        da2 = 8'h55;
        sb_push(7, 2, 16'h0055, "rdw_new_55");
        tick();
        aa2 = 4'd9; da2 = 8'h7E;
        sb_push(7, 2, 16'h007E, "oreg_wr");
        tick();
        wa2 = 0; aa2 = 4'd0;
        sb_push(7, 2, 16'h0000, "oreg_idle");
        tick();
        aa2 = 4'd9;
        sb_push(7, 2, 16'h007E, "oreg_rd");
        tick();
        tick();
        tick();

        // Byte-lane writes on the 16-bit instance.
        wa1 = 1; aa1 = 4'd3; da1 = 16'h1234; bea1 = 2'b11;
        sb_push(4, 1, 16'h1234, "be_full");
        tick();
        da1 = 16'hABCD; bea1 = 2'b01;
        sb_push(4, 1, 16'h12CD, "be_low");
        tick();
        wa1 = 0; ab1 = 4'd3;
        sb_push(4, 1, 16'h12CD, "be_rd_a");
        sb_push(5, 1, 16'h12CD, "be_rd_b");
        sb_push(6, 1, 16'h0000, "no_coll");
        tick();

        // Collision with overlapping lanes: A wins the shared lane.
        wa1 = 1; aa1 = 4'd7; da1 = 16'h1111; bea1 = 2'b01;
        wb1 = 1; ab1 = 4'd7; db1 = 16'h2222; beb1 = 2'b11;
        sb_push(4, 1, 16'h2211, "coll_qa");
        sb_push(5, 1, 16'h2211, "coll_qb");
        sb_push(6, 1, 16'h0001, "coll_pulse");
        sb_push(6, 2, 16'h0000, "coll_end");
        tick();
        wa1 = 0; wb1 = 0; aa1 = 4'd7;
        sb_push(4, 1, 16'h2211, "coll_word");
        tick();

        // Collision with disjoint lanes still flags.
        wa1 = 1; aa1 = 4'd8; da1 = 16'h00AA; bea1 = 2'b01;
        wb1 = 1; ab1 = 4'd8; db1 = 16'hBB00; beb1 = 2'b10;
        sb_push(6, 1, 16'h0001, "coll_disjoint");
        sb_push(4, 1, 16'hBBAA, "disj_qa");
        sb_push(5, 1, 16'hBBAA, "disj_qb");
        tick();

        // Distinct addresses: no collision.
        aa1 = 4'd9;  da1 = 16'h1357; bea1 = 2'b11;
        ab1 = 4'd10; db1 = 16'h2468; beb1 = 2'b11;
        sb_push(6, 1, 16'h0000, "coll_diff_addr");
        sb_push(4, 1, 16'h1357, "diff_qa");
        sb_push(5, 1, 16'h2468, "diff_qb");
        tick();

        // Cross-port RDW returns the pre-write word.
        wb1 = 0; ab1 = 4'd3;
        aa1 = 4'd3; da1 = 16'hFFFF; bea1 = 2'b11;
        sb_push(5, 1, 16'h12CD, "xport_old");
        sb_push(4, 1, 16'hFFFF, "xport_qa");
        tick();

        // Write with no lanes enabled changes nothing.
        da1 = 16'h0000; bea1 = 2'b00;
        sb_push(4, 1, 16'hFFFF, "be_none");
        tick();
        wa1 = 0; aa1 = 4'd8; ab1 = 4'd3;
        sb_push(4, 1, 16'hBBAA, "final_8");
        sb_push(5, 1, 16'hFFFF, "final_3");
        tick();

        repeat (4) tick();
        check_val("sb_drain", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
